syn_tle_kacc: RTL and testbench

SYN_TLE_KACC -- requirements
Module: syn_tle_kacc

---
 rtl/syn_tle_kacc.sv | 171 +++++++++++++++++
 tb/tb_syn_tle_kacc.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_tle_kacc.sv
// Tiled matrix multiply-accumulate: D = C + sum over beats of A*B, with selectable
// subword precision and a fixed-depth product pipeline ahead of the accumulator.
module syn_tle_kacc #(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int K          = 2,
    parameter int P          = 8,
    parameter int PIPESTAGES = 1,
    parameter int MAXTILES   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic signed [M-1:0][K-1:0][P-1:0]     A_i,
    input  logic signed [K-1:0][N-1:0][P-1:0]     B_i,
    input  logic signed [M-1:0][N-1:0][4*P-1:0]   C_i,
    input  logic [1:0]                            prec_i,
    input  logic [$clog2(MAXTILES+1)-1:0]         tiles_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    output logic signed [M-1:0][N-1:0][4*P-1:0]   D_o,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic                                  busy_o
);
    localparam int TW = $clog2(MAXTILES+1);
    localparam int W  = 4*P;
    localparam int H  = P/2;
    localparam int Q  = P/4;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                       state_reg, state_next;
    logic [TW-1:0]                count_reg, tiles_reg, tiles_eff;
    logic [1:0]                   prec_reg, mode_eff;
    logic                         accept, last_beat;
    logic [M-1:0][N-1:0][W-1:0]   c_reg;
    logic [W-1:0]                 acc_reg   [M][N];
    logic [W-1:0]                 beat_res  [M][N];
    logic [W-1:0]                 pipe_data [PIPESTAGES][M][N];
    logic                         pipe_vld   [PIPESTAGES];
    logic                         pipe_first [PIPESTAGES];
    logic                         pipe_last  [PIPESTAGES];
    logic                         ex_vld, ex_first, ex_last;

    // Mode 3 is reserved and falls through to the full-width product.
    function automatic logic [W-1:0] elem_prod(input logic [P-1:0] a, input logic [P-1:0] b,
                                               input logic [1:0] mode);
        logic signed [W-1:0] sum;
        sum = '0;
        case (mode)
            2'd1: for (int l = 0; l < 2; l++)
                sum = sum + W'($signed(a[l*H +: H])) * W'($signed(b[l*H +: H]));
            2'd2: for (int l = 0; l < 4; l++)
                sum = sum + W'($signed(a[l*Q +: Q])) * W'($signed(b[l*Q +: Q]));
            default: sum = W'($signed(a)) * W'($signed(b));
        endcase
        return sum;
    endfunction

    // The first beat of a job computes with the live prec_i; later beats use the latched mode.
    assign mode_eff  = (state_reg == IDLE) ? prec_i : prec_reg;
    assign tiles_eff = (tiles_i == '0) ? TW'(1) : tiles_i;
    assign accept    = valid_i & ready_o;
    assign last_beat = (state_reg == IDLE) ? (tiles_eff == TW'(1))
                                           : ((count_reg + TW'(1)) == tiles_reg);
    assign busy_o    = (state_reg != IDLE);
    assign ex_vld    = pipe_vld[PIPESTAGES-1];
    assign ex_first  = pipe_first[PIPESTAGES-1];
    assign ex_last   = pipe_last[PIPESTAGES-1];

    genvar gi, gj;
    generate
        for (gi = 0; gi < M; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                always_comb begin
                    beat_res[gi][gj] = '0;
                    for (int k = 0; k < K; k++)
                        beat_res[gi][gj] = beat_res[gi][gj] + elem_prod(A_i[gi][k], B_i[k][gj], mode_eff);
                end
                assign D_o[gi][gj] = acc_reg[gi][gj];
            end
        end

        for (gi = 0; gi < PIPESTAGES; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk_i) pipe_data[0] <= beat_res;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        pipe_vld[0]   <= 1'b0;
                        pipe_first[0] <= 1'b0;
                        pipe_last[0]  <= 1'b0;
                    end else begin
                        pipe_vld[0]   <= accept;
                        pipe_first[0] <= accept && (state_reg == IDLE);
                        pipe_last[0]  <= accept && last_beat;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk_i) pipe_data[gi] <= pipe_data[gi-1];
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        pipe_vld[gi]   <= 1'b0;
                        pipe_first[gi] <= 1'b0;
                        pipe_last[gi]  <= 1'b0;
                    end else begin
                        pipe_vld[gi]   <= pipe_vld[gi-1];
                        pipe_first[gi] <= pipe_first[gi-1];
                        pipe_last[gi]  <= pipe_last[gi-1];
                    end
                end
            end
        end
    endgenerate

    // ready_o is forced low while reset is held, and rises as soon as it is released.
    always_comb begin
        state_next = state_reg;
        ready_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) state_next = ACC;
            end
            ACC: begin
                ready_o = (count_reg < tiles_reg);
                if (ex_vld && ex_last) state_next = HOLD;
            end
            HOLD: if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_o = ready_o & rst_ni;
    end

    always_ff @(posedge clk_i) begin
        if (accept && (state_reg == IDLE)) c_reg <= C_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            count_reg <= '0;
            tiles_reg <= '0;
            prec_reg  <= '0;
            valid_o   <= 1'b0;
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++)
                    acc_reg[m][n] <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                if (state_reg == IDLE) begin
                    prec_reg  <= prec_i;
                    tiles_reg <= tiles_eff;
                    count_reg <= TW'(1);
                end else begin
                    count_reg <= count_reg + TW'(1);
                end
            end
            if (ex_vld) begin
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++)
                        acc_reg[m][n] <= (ex_first ? c_reg[m][n] : acc_reg[m][n])
                                         + pipe_data[PIPESTAGES-1][m][n];
            end
            if (ex_vld && ex_last)
                valid_o <= 1'b1;
            else if ((state_reg == HOLD) && ready_i)
                valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_syn_tle_kacc.sv
// Self-checking bench for syn_tle_kacc: directed scenarios plus random jobs
// checked against an arithmetic reference of the multiply-accumulate.
module tb_syn_tle_kacc;
    localparam int M = 2, N = 2, K = 2, P = 8, PS = 1, MT = 16;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic signed [M-1:0][K-1:0][P-1:0]   A_i;
    logic signed [K-1:0][N-1:0][P-1:0]   B_i;
    logic signed [M-1:0][N-1:0][4*P-1:0] C_i;
    logic [1:0]  prec_i;
    logic [4:0]  tiles_i;
    logic        valid_i, ready_o, valid_o, ready_i, busy_o;
    logic signed [M-1:0][N-1:0][4*P-1:0] D_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ja [16][2][2];
    logic [7:0]  jb [16][2][2];
    logic [31:0] jc [2][2];
    logic [31:0] exp_d [2][2];
    int          jtiles;
    logic [1:0]  jmode;

    syn_tle_kacc #(.M(M), .N(N), .K(K), .P(P), .PIPESTAGES(PS), .MAXTILES(MT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .A_i(A_i), .B_i(B_i), .C_i(C_i),
        .prec_i(prec_i), .tiles_i(tiles_i), .valid_i(valid_i), .ready_o(ready_o),
        .D_o(D_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic longint sx(input logic [7:0] x, input int lo, input int w);
        longint v;
        v = longint'((x >> lo) & ((1 << w) - 1));
        if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint eprod(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode);
        longint s;
        s = 0;
        if (mode == 2'd1) begin
            s = sx(a, 0, 4) * sx(b, 0, 4) + sx(a, 4, 4) * sx(b, 4, 4);
        end else if (mode == 2'd2) begin
            for (int l = 0; l < 4; l++) s = s + sx(a, 2*l, 2) * sx(b, 2*l, 2);
        end else begin
            s = sx(a, 0, 8) * sx(b, 0, 8);
        end
        return s;
    endfunction

    task automatic model();
        int nb;
        logic [31:0] acc;
        nb = (jtiles == 0) ? 1 : jtiles;
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                acc = jc[m][n];
                for (int t = 0; t < nb; t++)
                    for (int k = 0; k < K; k++)
                        acc = acc + 32'(eprod(ja[t][m][k], jb[t][k][n], jmode));
                exp_d[m][n] = acc;
            end
    endtask

    task automatic set_const(input logic [7:0] a, input logic [7:0] b, input logic [31:0] c);
        for (int t = 0; t < 16; t++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    ja[t][i][j] = a;
                    jb[t][i][j] = b;
                end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) jc[i][j] = c;
    endtask

    // Drives every beat of the job back-to-back, then waits for valid_o and checks latency and D.
    task automatic send_job(input string name);
        int nb;
        int lat;
        nb = (jtiles == 0) ? 1 : jtiles;
        model();
        for (int t = 0; t < nb; t++) begin
            for (int m = 0; m < M; m++)
                for (int k = 0; k < K; k++) A_i[m][k] = ja[t][m][k];
            for (int k = 0; k < K; k++)
                for (int n = 0; n < N; n++) B_i[k][n] = jb[t][k][n];
            if (t == 0) begin
                prec_i  = jmode;
                tiles_i = 5'(jtiles);
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++) C_i[m][n] = jc[m][n];
            end else begin
                prec_i  = 2'($urandom);
                tiles_i = 5'($urandom);
                for (int m = 0; m < M; m++)
                    for (int n = 0; n < N; n++) C_i[m][n] = $urandom;
            end
            valid_i = 1'b1;
            #1;
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_beat%0d: got %b expected 1", name, t, ready_o);
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        A_i = {$urandom, $urandom};
        B_i = {$urandom, $urandom};
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_after_last: got %b expected 0", name, ready_o);
        end
        lat = 0;
        while (valid_o !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != PS) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, PS);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_hold: got %b expected 1", name, busy_o);
        end
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                checks++;
                if (D_o[m][n] !== exp_d[m][n]) begin
                    errors++;
                    $display("FAIL %s D[%0d][%0d]: got %h expected %h", name, m, n, D_o[m][n], exp_d[m][n]);
                end
            end
        $display("JOB %s mode %0d tiles %0d D %h %h %h %h", name, jmode, jtiles,
                 D_o[0][0], D_o[0][1], D_o[1][0], D_o[1][1]);
    endtask

    task automatic finish_job(input string name);
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: got valid %b busy %b ready %b expected 0 0 1",
                     name, valid_o, busy_o, ready_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0 || busy_o !== 1'b0 || D_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready %b valid %b busy %b D %h expected 0 0 0 0",
                     ready_o, valid_o, busy_o, D_o);
        end
        rst_ni = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready %b busy %b expected 1 0", ready_o, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        set_const(8'd1, 8'd2, 32'd3);
        jtiles = 1;
        jmode  = 2'd0;
        send_job("single");
        finish_job("single");
    endtask

    task automatic test_back_to_back();
        set_const(8'd1, 8'd2, 32'd3);
        jtiles = 3;
        jmode  = 2'd0;
        send_job("kacc3");
        finish_job("kacc3");
    endtask

    task automatic test_precision();
        set_const(8'h11, 8'h11, 32'h11);
        jtiles = 1;
        jmode  = 2'd1;
        send_job("prec1");
        finish_job("prec1");
        set_const(8'h55, 8'h55, 32'd0);
        jmode = 2'd2;
        send_job("prec2");
        finish_job("prec2");
        set_const(8'h80, 8'h80, 32'd0);
        jmode = 2'd0;
        send_job("prec0");
        finish_job("prec0");
        set_const(8'h7f, 8'h81, 32'd5);
        jmode = 2'd3;
        send_job("prec3");
        finish_job("prec3");
    endtask

    task automatic test_backpressure();
        logic signed [M-1:0][N-1:0][4*P-1:0] snap;
        set_const(8'd1, 8'd2, 32'd3);
        jtiles  = 2;
        jmode   = 2'd0;
        ready_i = 1'b0;
        send_job("bp");
        snap = D_o;
        for (int c = 0; c < 5; c++) begin
            valid_i = 1'b1;
            tiles_i = 5'd1;
            prec_i  = 2'd0;
            @(negedge clk);
            checks++;
            if (D_o !== snap || valid_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got D %h valid %b ready %b expected D %h valid 1 ready 0",
                         c, D_o, valid_o, ready_o, snap);
            end
        end
        ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_ready: got valid %b ready %b expected 0 1", valid_o, ready_o);
        end
        set_const(8'd3, 8'd1, 32'h100);
        jtiles = 1;
        send_job("bp_next");
        finish_job("bp_next");
    endtask

    task automatic test_reset_mid_job();
        int seen;
        set_const(8'd1, 8'd2, 32'd3);
        ready_i = 1'b1;
        for (int t = 0; t < 2; t++) begin
            A_i = '0;
            B_i = '0;
            for (int m = 0; m < M; m++)
                for (int k = 0; k < K; k++) A_i[m][k] = 8'd1;
            for (int k = 0; k < K; k++)
                for (int n = 0; n < N; n++) B_i[k][n] = 8'd2;
            for (int m = 0; m < M; m++)
                for (int n = 0; n < N; n++) C_i[m][n] = 32'd3;
            prec_i  = 2'd0;
            tiles_i = 5'd4;
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        checks++;
        if (D_o !== '0 || valid_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_state: got D %h valid %b busy %b ready %b expected all 0",
                     D_o, valid_o, busy_o, ready_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1 || busy_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen);
        end
        set_const(8'd2, 8'd3, 32'd1);
        jtiles = 1;
        jmode  = 2'd0;
        send_job("after_rst");
        finish_job("after_rst");
    endtask

    task automatic test_wrap_tiles0();
        set_const(8'd1, 8'd1, 32'h7fff_ffff);
        for (int i = 0; i < 2; i++) ja[0][i][1] = 8'd0;
        jtiles = 0;
        jmode  = 2'd0;
        send_job("wrap");
        checks++;
        if (D_o[1][1] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL wrap_value: got %h expected 80000000", D_o[1][1]);
        end
        finish_job("wrap");
    endtask

    task automatic test_random();
        int stall;
        logic signed [M-1:0][N-1:0][4*P-1:0] snap;
        for (int it = 0; it < 12; it++) begin
            jtiles = $urandom_range(0, 5);
            jmode  = 2'($urandom);
            for (int t = 0; t < 16; t++)
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        ja[t][i][j] = 8'($urandom);
                        jb[t][i][j] = 8'($urandom);
                    end
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) jc[i][j] = $urandom;
            stall   = $urandom_range(0, 3);
            ready_i = (stall == 0);
            send_job($sformatf("rand%0d", it));
            snap = D_o;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                checks++;
                if (D_o !== snap || valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rand%0d stall%0d: got D %h valid %b expected D %h valid 1",
                             it, c, D_o, valid_o, snap);
                end
            end
            finish_job($sformatf("rand%0d", it));
        end
    endtask

    initial begin
        A_i = '0; B_i = '0; C_i = '0;
        prec_i = 2'd0; tiles_i = 5'd0;
        valid_i = 1'b0; ready_i = 1'b1;
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_precision();
        test_backpressure();
        test_reset_mid_job();
        test_wrap_tiles0();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
